// File: rtl/boot_loader_pkg.sv
// rtl/boot_loader_pkg.sv - shared state encoding and helpers for the boot loader
package boot_loader_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RECV  = 3'd1,
        WRITE = 3'd2,
        HOLD  = 3'd3,
        RUN   = 3'd4,
        ERROR = 3'd5
    } loader_state_t;

    // Plain constants so the state register stays a bare vector for older tools
    localparam logic [2:0] ST_IDLE  = 3'(IDLE);
    localparam logic [2:0] ST_RECV  = 3'(RECV);
    localparam logic [2:0] ST_WRITE = 3'(WRITE);
    localparam logic [2:0] ST_HOLD  = 3'(HOLD);
    localparam logic [2:0] ST_RUN   = 3'(RUN);
    localparam logic [2:0] ST_ERROR = 3'(ERROR);

    localparam logic [3:0] WSTRB_WORD = 4'hF;

    // Byte address of word idx of the image; wraps at 32 bits
    function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] idx);
        return base + (idx << 2);
    endfunction

endpackage

// File: rtl/boot_loader_mem_if_mux.sv
// rtl/boot_loader_mem_if_mux.sv - 2:1 native memory interface mux (loader vs cpu)
module boot_loader_mem_if_mux (
    input  logic        sel,
    input  logic        ld_valid,
    input  logic [31:0] ld_addr,
    input  logic [31:0] ld_wdata,
    input  logic [3:0]  ld_wstrb,
    input  logic        cpu_valid,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_wstrb,
    output logic        cpu_ready,
    output logic        mem_valid,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready
);

    // sel=1 hands the bus to the cpu; otherwise the loader owns it and the cpu sees no ready
    always_comb begin
        mem_valid = sel ? cpu_valid : ld_valid;
        mem_addr  = sel ? cpu_addr  : ld_addr;
        mem_wdata = sel ? cpu_wdata : ld_wdata;
        mem_wstrb = sel ? cpu_wstrb : ld_wstrb;
        cpu_ready = sel & mem_ready;
    end

endmodule

// File: rtl/boot_loader.sv
// rtl/boot_loader.sv - streams a program image into BRAM, then releases the cpu
module boot_loader
    import boot_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 256,
    parameter int          BOOT_HOLD = 4
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           start,
    input  logic                           s_valid,
    input  logic [31:0]                    s_data,
    input  logic                           s_last,
    output logic                           s_ready,
    input  logic                           cpu_mem_valid,
    input  logic [31:0]                    cpu_mem_addr,
    input  logic [31:0]                    cpu_mem_wdata,
    input  logic [3:0]                     cpu_mem_wstrb,
    output logic                           cpu_mem_ready,
    output logic                           mem_valid,
    output logic [31:0]                    mem_addr,
    output logic [31:0]                    mem_wdata,
    output logic [3:0]                     mem_wstrb,
    input  logic                           mem_ready,
    output logic                           cpu_reset_n,
    output logic                           busy,
    output logic                           done,
    output logic                           error,
    output logic [$clog2(MAX_WORDS+1)-1:0] word_count
);

    localparam int WC_W = $clog2(MAX_WORDS + 1);
    localparam int HC_W = (BOOT_HOLD > 1) ? $clog2(BOOT_HOLD) : 1;

    logic [2:0]      state;
    logic [HC_W-1:0] hold_cnt;
    logic [31:0]     ld_addr;
    logic [31:0]     ld_wdata;
    logic [3:0]      ld_wstrb;
    logic            ld_last;
    logic            in_run;

    // Status and handshake outputs decode straight from the state register
    always_comb begin
        in_run      = (state == ST_RUN);
        s_ready     = (state == ST_RECV);
        cpu_reset_n = in_run;
        done        = in_run;
        busy        = (state == ST_RECV) || (state == ST_WRITE) || (state == ST_HOLD);
    end

    // Load FSM: capture a word, write it once, repeat until last, then hold the cpu in reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            hold_cnt   <= '0;
            ld_addr    <= BASE_ADDR;
            ld_wdata   <= '0;
            ld_wstrb   <= '0;
            ld_last    <= 1'b0;
            word_count <= '0;
            error      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_RUN, ST_ERROR: begin
                    // A reload from RUN abandons any cpu transaction in flight
                    if (start) begin
                        state      <= ST_RECV;
                        word_count <= '0;
                        error      <= 1'b0;
                    end
                end
                ST_RECV: begin
                    if (s_valid) begin
                        if (word_count == WC_W'(MAX_WORDS)) begin
                            // Image too long: swallow the word and park
                            error <= 1'b1;
                            state <= ST_ERROR;
                        end else begin
                            ld_wdata <= s_data;
                            ld_addr  <= word_addr(BASE_ADDR, 32'(word_count));
                            ld_wstrb <= WSTRB_WORD;
                            ld_last  <= s_last;
                            state    <= ST_WRITE;
                        end
                    end
                end
                ST_WRITE: begin
                    if (mem_ready) begin
                        word_count <= word_count + WC_W'(1);
                        hold_cnt   <= '0;
                        state      <= ld_last ? ST_HOLD : ST_RECV;
                    end
                end
                ST_HOLD: begin
                    if (hold_cnt == HC_W'(BOOT_HOLD - 1)) begin
                        state <= ST_RUN;
                    end else begin
                        hold_cnt <= hold_cnt + HC_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    boot_loader_mem_if_mux u_mux (
        .sel       (in_run),
        .ld_valid  (state == ST_WRITE),
        .ld_addr   (ld_addr),
        .ld_wdata  (ld_wdata),
        .ld_wstrb  (ld_wstrb),
        .cpu_valid (cpu_mem_valid),
        .cpu_addr  (cpu_mem_addr),
        .cpu_wdata (cpu_mem_wdata),
        .cpu_wstrb (cpu_mem_wstrb),
        .cpu_ready (cpu_mem_ready),
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ready (mem_ready)
    );

endmodule
